matmul_feeder: RTL and testbench

- Drives the row/column stream into the 3x3 matrix-multiply core (iter_parallel / iterative) and collects its result stream.
- Holds operand matrices A and B, loaded through a simple write port.
- On start, issues the 9 (row of A, column of B) pairs on row1/col2/axiiv, captures the 9 axiod results into a result buffer, then signals done.
- Sits between the host-side load/readback logic and the multiply core; it replaces the hand-written stimulus currently used to exercise the core.

---
 rtl/matmul_feeder.sv | 156 +++++++++++++++
 tb/tb_matmul_feeder.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/matmul_feeder.sv
// rtl/matmul_feeder.sv - operand/result sequencer for the 3x3 iterative matrix-multiply core
module matmul_feeder #(
  parameter int DATA_W        = 8,
  parameter int RES_W         = 16,
  parameter int ISSUE_GAP     = 0,
  parameter int DRAIN_TIMEOUT = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_en,
  input  logic                   wr_sel,
  input  logic [3:0]             wr_addr,
  input  logic [DATA_W-1:0]      wr_data,
  input  logic                   start,
  output logic                   busy,
  output logic                   done,
  output logic                   err,
  output logic [2:0][DATA_W-1:0] row1,
  output logic [2:0][DATA_W-1:0] col2,
  output logic                   axiiv,
  input  logic                   axiov,
  input  logic [RES_W-1:0]       axiod,
  input  logic [3:0]             rd_addr,
  output logic [RES_W-1:0]       rd_data
);

  localparam int GW = $clog2(ISSUE_GAP + 2);
  localparam int TW = $clog2(DRAIN_TIMEOUT + 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

  state_t                   state;
  logic [DATA_W-1:0]        a_mem [9];
  logic [DATA_W-1:0]        b_mem [9];
  logic [RES_W-1:0]         c_mem [9];
  logic [3:0]               np;
  logic [3:0]               q;
  logic [GW-1:0]            gap_cnt;
  logic [TW-1:0]            tmo_cnt;
  logic [3:0]               pidx;
  logic [3:0]               pi;
  logic [3:0]               pj;
  logic [2:0][DATA_W-1:0]   nrow;
  logic [2:0][DATA_W-1:0]   ncol;
  logic                     idle_like;
  logic                     can_start;
  logic                     capture;
  logic                     last_res;

  // Operands for the next pair; outside ISSUE this selects pair 0 so start can issue it directly.
  always_comb begin
    pidx = (state == S_ISSUE) ? np : 4'd0;
    pi   = pidx / 4'd3;
    pj   = pidx % 4'd3;
    nrow = '0;
    ncol = '0;
    for (int k = 0; k < 3; k++) begin
      nrow[k] = a_mem[pi * 4'd3 + 4'(k)];
      ncol[k] = b_mem[4'(k) * 4'd3 + pj];
    end
  end

  assign idle_like = (state == S_IDLE) || (state == S_DONE);
  assign can_start = start && idle_like;
  assign capture   = axiov && ((state == S_ISSUE) || (state == S_DRAIN));
  assign last_res  = capture && (q == 4'd8);

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
      axiiv   <= 1'b0;
      row1    <= '0;
      col2    <= '0;
      rd_data <= '0;
      np      <= '0;
      q       <= '0;
      gap_cnt <= '0;
      tmo_cnt <= '0;
      for (int i = 0; i < 9; i++) begin
        a_mem[i] <= '0;
        b_mem[i] <= '0;
        c_mem[i] <= '0;
      end
    end else begin
      rd_data <= (rd_addr <= 4'd8) ? c_mem[rd_addr] : '0;

      if (wr_en && idle_like && (wr_addr <= 4'd8)) begin
        if (wr_sel) b_mem[wr_addr] <= wr_data;
        else        a_mem[wr_addr] <= wr_data;
      end

      if (capture) begin
        c_mem[q] <= axiod;
        q        <= q + 4'd1;
      end

      case (state)
        S_IDLE, S_DONE: begin
          if (can_start) begin
            state   <= S_ISSUE;
            busy    <= 1'b1;
            done    <= 1'b0;
            err     <= 1'b0;
            axiiv   <= 1'b1;
            row1    <= nrow;
            col2    <= ncol;
            np      <= 4'd1;
            q       <= '0;
            gap_cnt <= GW'(ISSUE_GAP);
            tmo_cnt <= '0;
          end
        end
        S_ISSUE: begin
          if (gap_cnt != '0) begin
            gap_cnt <= gap_cnt - 1'b1;
            axiiv   <= 1'b0;
          end else begin
            axiiv   <= 1'b1;
            row1    <= nrow;
            col2    <= ncol;
            np      <= np + 4'd1;
            gap_cnt <= GW'(ISSUE_GAP);
            if (np == 4'd8) state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          axiiv <= 1'b0;
          if (capture) begin
            tmo_cnt <= '0;
          end else if (tmo_cnt == TW'(DRAIN_TIMEOUT - 1)) begin
            state <= S_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            err   <= 1'b1;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase

      // The ninth result completes the run regardless of where issue currently stands.
      if (last_res) begin
        state <= S_DONE;
        busy  <= 1'b0;
        done  <= 1'b1;
        err   <= 1'b0;
        axiiv <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_matmul_feeder.sv
// tb/tb_matmul_feeder.sv - self-checking bench for matmul_feeder (ISSUE_GAP 0 and 2 side by side)
module tb_matmul_feeder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst = 1'b1, wr_en = 1'b0, wr_sel = 1'b0, start = 1'b0;
  logic [3:0] wr_addr = '0, rd_addr = '0;
  logic [7:0] wr_data = '0;

  logic            busy [2], done [2], err [2], axiiv [2], axiov [2];
  logic [2:0][7:0] row1 [2], col2 [2];
  logic [15:0]     axiod [2], rd_data [2];

  matmul_feeder #(.DATA_W(8), .RES_W(16), .ISSUE_GAP(0), .DRAIN_TIMEOUT(64)) u_dut0 (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_sel(wr_sel), .wr_addr(wr_addr), .wr_data(wr_data),
    .start(start), .busy(busy[0]), .done(done[0]), .err(err[0]), .row1(row1[0]), .col2(col2[0]),
    .axiiv(axiiv[0]), .axiov(axiov[0]), .axiod(axiod[0]), .rd_addr(rd_addr), .rd_data(rd_data[0]));

  matmul_feeder #(.DATA_W(8), .RES_W(16), .ISSUE_GAP(2), .DRAIN_TIMEOUT(64)) u_dut1 (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_sel(wr_sel), .wr_addr(wr_addr), .wr_data(wr_data),
    .start(start), .busy(busy[1]), .done(done[1]), .err(err[1]), .row1(row1[1]), .col2(col2[1]),
    .axiiv(axiiv[1]), .axiov(axiov[1]), .axiod(axiod[1]), .rd_addr(rd_addr), .rd_data(rd_data[1]));

  // Core model: dot product returned two cycles after the pair, optionally dropping results 7 and 8.
  logic        cv1 [2], cv2 [2];
  logic [15:0] cd1 [2], cd2 [2];
  int          ridx [2];
  bit          drop2 = 1'b0;

  function automatic logic [15:0] dot(input logic [2:0][7:0] r, input logic [2:0][7:0] c);
    logic [15:0] s;
    s = '0;
    for (int k = 0; k < 3; k++) s += 16'(r[k]) * 16'(c[k]);
    return s;
  endfunction

  always @(posedge clk) begin
    for (int n = 0; n < 2; n++) begin
      if (rst) begin
        cv1[n]  <= 1'b0;
        cv2[n]  <= 1'b0;
        ridx[n] <= 0;
      end else begin
        cv1[n] <= axiiv[n];
        cd1[n] <= dot(row1[n], col2[n]);
        cv2[n] <= cv1[n];
        cd2[n] <= cd1[n];
        if (start && !busy[n]) ridx[n] <= 0;
        else if (cv2[n])       ridx[n] <= ridx[n] + 1;
      end
    end
  end

  assign axiov[0] = cv2[0] && !(drop2 && ridx[0] >= 7);
  assign axiov[1] = cv2[1] && !(drop2 && ridx[1] >= 7);
  assign axiod[0] = cd2[0];
  assign axiod[1] = cd2[1];

  logic [7:0]      ma [9], mb [9];
  logic [15:0]     mc [9];
  int              pcnt [2], lastc [2], done_cyc [2];
  int              cyc = 0, checks = 0, failures = 0;
  logic [2:0][7:0] p1_row, p1_col;
  int ones [9] = '{1, 1, 1, 1, 1, 1, 1, 1, 1};
  int seq  [9] = '{1, 2, 3, 4, 5, 6, 7, 8, 9};
  int iden [9] = '{1, 0, 0, 0, 1, 0, 0, 0, 1};
  int lsq  [9] = '{30, 36, 42, 66, 81, 96, 102, 126, 150};

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", nm, got, exp);
    end
  endtask

  // One clock; every issued pair is checked against A row i / B column j of the model.
  task automatic tick();
    logic [2:0][7:0] er, ec;
    int p;
    @(posedge clk);
    #1;
    cyc++;
    for (int n = 0; n < 2; n++) begin
      if (axiiv[n] === 1'b1) begin
        p = pcnt[n];
        for (int k = 0; k < 3; k++) begin
          er[k] = ma[(p / 3) * 3 + k];
          ec[k] = mb[k * 3 + (p % 3)];
        end
        chk(n == 1 ? "pair_gap2" : "pair_gap0", {row1[n], col2[n]}, {er, ec});
        if (p > 0) chk("issue_spacing", cyc - lastc[n], (n == 0) ? 1 : 3);
        lastc[n] = cyc;
        if (n == 0 && p == 1) begin
          p1_row = row1[0];
          p1_col = col2[0];
        end
        pcnt[n]++;
      end
    end
  endtask

  task automatic set_model_c();
    logic [15:0] s;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++) begin
        s = '0;
        for (int k = 0; k < 3; k++) s += 16'(ma[i * 3 + k]) * 16'(mb[k * 3 + j]);
        mc[i * 3 + j] = s;
      end
  endtask

  task automatic clear_model();
    for (int a = 0; a < 9; a++) begin
      ma[a] = '0;
      mb[a] = '0;
      mc[a] = '0;
    end
  endtask

  task automatic wr(input bit sel, input int addr, input int data);
    wr_en   = 1'b1;
    wr_sel  = sel;
    wr_addr = 4'(addr);
    wr_data = 8'(data);
    tick();
    wr_en = 1'b0;
    if (addr < 9) begin
      if (sel) mb[addr] = 8'(data);
      else     ma[addr] = 8'(data);
    end
  endtask

  task automatic load(input bit sel, input int v [9]);
    for (int a = 0; a < 9; a++) wr(sel, a, v[a]);
  endtask

  task automatic begin_run();
    start = 1'b1;
    pcnt  = '{0, 0};
    tick();
    start = 1'b0;
    for (int n = 0; n < 2; n++) begin
      chk("axiiv_after_start", axiiv[n], 1);
      chk("busy_in_run", busy[n], 1);
    end
  endtask

  task automatic wait_done(input bit exp_err);
    bit seen [2];
    int t;
    seen = '{0, 0};
    t = 0;
    while (!(done[0] === 1'b1 && done[1] === 1'b1) && t < 400) begin
      tick();
      t++;
      for (int n = 0; n < 2; n++)
        if (done[n] === 1'b1 && !seen[n]) begin
          seen[n]     = 1'b1;
          done_cyc[n] = cyc;
          chk("busy_at_done", busy[n], 0);
        end
    end
    chk("done_reached", (done[0] === 1'b1) && (done[1] === 1'b1), 1);
    for (int n = 0; n < 2; n++) begin
      chk("err", err[n], exp_err);
      chk("pairs_issued", pcnt[n], 9);
    end
  endtask

  task automatic rd(input int a);
    rd_addr = 4'(a);
    tick();
  endtask

  task automatic readback();
    for (int i = 0; i < 11; i++) begin
      int a;
      a = (i == 10) ? 15 : i;
      rd(a);
      for (int n = 0; n < 2; n++) begin
        if (a < 9) chk("rd_c", rd_data[n], mc[a]);
        else       chk("rd_out_of_range", rd_data[n], 0);
      end
    end
  endtask

  initial begin
    int sc;
    logic [15:0] old7, old8;
    clear_model();
    pcnt = '{0, 0};
    repeat (3) tick();
    rst = 1'b0;
    for (int n = 0; n < 2; n++) begin
      chk("reset_busy", busy[n], 0);
      chk("reset_done", done[n], 0);
      chk("reset_err", err[n], 0);
      chk("reset_axiiv", axiiv[n], 0);
      chk("reset_rd_data", rd_data[n], 0);
    end

    // All-ones operands
    load(0, ones);
    load(1, ones);
    wr(0, 12, 77);
    set_model_c();
    begin_run();
    wait_done(0);
    readback();
    rd(4);
    chk("lit_ones_c4", rd_data[0], 3);
    chk("done_held", done[0], 1);

    // Sequence times identity
    load(0, seq);
    load(1, iden);
    set_model_c();
    begin_run();
    wait_done(0);
    chk("lit_p1_row", p1_row, {8'd3, 8'd2, 8'd1});
    chk("lit_p1_col", p1_col, {8'd0, 8'd1, 8'd0});
    readback();
    for (int a = 0; a < 9; a++) begin
      rd(a);
      chk("lit_ident", rd_data[0], a + 1);
    end

    // Sequence squared
    load(1, seq);
    set_model_c();
    begin_run();
    wait_done(0);
    readback();
    for (int a = 0; a < 9; a++) begin
      rd(a);
      chk("lit_square", rd_data[1], lsq[a]);
    end

    // Last two results dropped: drain timeout, C[7..8] keep the previous run's values
    load(0, ones);
    old7 = mc[7];
    old8 = mc[8];
    set_model_c();
    mc[7] = old7;
    mc[8] = old8;
    drop2 = 1'b1;
    sc = cyc;
    begin_run();
    wait_done(1);
    drop2 = 1'b0;
    chk("timeout_window", (done_cyc[0] - sc >= 70) && (done_cyc[0] - sc <= 80), 1);
    readback();
    rd(6);
    chk("lit_drop_c6", rd_data[0], 12);
    rd(7);
    chk("lit_drop_c7", rd_data[0], 126);
    rd(8);
    chk("lit_drop_c8", rd_data[1], 150);

    // Reset in the middle of issue
    load(0, seq);
    load(1, iden);
    set_model_c();
    begin_run();
    for (int t = 0; t < 20 && pcnt[0] < 5; t++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int n = 0; n < 2; n++) begin
      chk("midrun_reset_axiiv", axiiv[n], 0);
      chk("midrun_reset_busy", busy[n], 0);
      chk("midrun_reset_done", done[n], 0);
    end
    clear_model();
    readback();
    begin_run();
    wait_done(0);
    readback();

    // start and operand write while busy are ignored
    load(0, seq);
    load(1, iden);
    set_model_c();
    begin_run();
    tick();
    start   = 1'b1;
    wr_en   = 1'b1;
    wr_sel  = 1'b0;
    wr_addr = 4'd0;
    wr_data = 8'd99;
    tick();
    start = 1'b0;
    wr_en = 1'b0;
    wait_done(0);
    readback();
    rd(0);
    chk("lit_frozen_c0", rd_data[0], 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
